// File: rtl/bcd_pkg.sv
// Shared BCD constants and helpers for the multi-decade up/down counter.
package bcd_pkg;

   localparam logic [3:0] BCD_MAX = 4'd9;
   localparam logic [3:0] BCD_MIN = 4'd0;

   function automatic logic bcd_valid(input logic [3:0] d);
      return (d <= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_updown_digit.sv
// One decimal digit of the cascaded counter: clear/load/step with wrap or hold at the global limit.
module bcd_updown_digit
   import bcd_pkg::*;
#(
   parameter int SATURATE = 0
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] load_digit,
   input  logic       step,
   input  logic       up_dn,
   input  logic       limit,
   output logic [3:0] q,
   output logic       at_max,
   output logic       at_min
);

   localparam bit SAT_EN = (SATURATE != 0);

   logic [3:0] q_q;
   logic [3:0] q_d;
   logic       step_ok;

   // At the global limit a saturating counter freezes every digit, including the carrying ones.
   assign step_ok = step & ~(SAT_EN & limit);

   always_comb begin
      q_d = q_q;
      if (clear) begin
         q_d = BCD_MIN;
      end else if (load) begin
         q_d = bcd_valid(load_digit) ? load_digit : BCD_MIN;
      end else if (step_ok) begin
         if (up_dn) begin
            q_d = (q_q == BCD_MAX) ? BCD_MIN : q_q + 4'd1;
         end else begin
            q_d = (q_q == BCD_MIN) ? BCD_MAX : q_q - 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         q_q <= BCD_MIN;
      end else begin
         q_q <= q_d;
      end
   end

   assign q      = q_q;
   assign at_max = (q_q == BCD_MAX);
   assign at_min = (q_q == BCD_MIN);

endmodule

// File: rtl/bcd_updown_counter_n.sv
// NUM_DIGITS-decade BCD up/down counter with clear, parallel load and optional saturation.
module bcd_updown_counter_n
   import bcd_pkg::*;
#(
   parameter int NUM_DIGITS = 3,
   parameter int SATURATE   = 0
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic                    up_dn,
   input  logic                    clear,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] load_value,
   output logic [4*NUM_DIGITS-1:0] count,
   output logic                    terminal,
   output logic                    rollover,
   output logic                    load_err
);

   localparam bit SAT_EN = (SATURATE != 0);

   logic [NUM_DIGITS:0]   up_chain;
   logic [NUM_DIGITS:0]   dn_chain;
   logic [NUM_DIGITS-1:0] step;
   logic [NUM_DIGITS-1:0] at_max;
   logic [NUM_DIGITS-1:0] at_min;
   logic                  load_bad;
   logic                  rollover_q, rollover_d;
   logic                  load_err_q, load_err_d;

   // up_chain[i] is high when every digit below i sits at 9; dn_chain likewise for 0.
   assign up_chain[0] = 1'b1;
   assign dn_chain[0] = 1'b1;

   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      assign up_chain[i+1] = up_chain[i] & at_max[i];
      assign dn_chain[i+1] = dn_chain[i] & at_min[i];
      assign step[i]       = enable & (up_dn ? up_chain[i] : dn_chain[i]);

      bcd_updown_digit #(
         .SATURATE (SATURATE)
      ) u_digit (
         .clk        (clk),
         .reset_n    (reset_n),
         .clear      (clear),
         .load       (load),
         .load_digit (load_value[4*i +: 4]),
         .step       (step[i]),
         .up_dn      (up_dn),
         .limit      (terminal),
         .q          (count[4*i +: 4]),
         .at_max     (at_max[i]),
         .at_min     (at_min[i])
      );
   end

   assign terminal = up_dn ? up_chain[NUM_DIGITS] : dn_chain[NUM_DIGITS];

   always_comb begin
      load_bad = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (!bcd_valid(load_value[4*i +: 4])) begin
            load_bad = 1'b1;
         end
      end
   end

   assign rollover_d = ~clear & ~load & enable & terminal & ~SAT_EN;
   assign load_err_d = ~clear & load & load_bad;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rollover_q <= 1'b0;
         load_err_q <= 1'b0;
      end else begin
         rollover_q <= rollover_d;
         load_err_q <= load_err_d;
      end
   end

   assign rollover = rollover_q;
   assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Directed vector bench for the BCD up/down counter: 3-digit wrap, 3-digit saturate and 1-digit builds.
module tb_bcd_updown_counter_n;

   logic clk;
   logic reset_n;

   // DUT A: NUM_DIGITS=3, SATURATE=0
   logic        a_en, a_ud, a_clr, a_ld;
   logic [11:0] a_lv, a_cnt;
   logic        a_term, a_roll, a_lerr;
   // DUT B: NUM_DIGITS=3, SATURATE=1
   logic        b_en, b_ud, b_clr, b_ld;
   logic [11:0] b_lv, b_cnt;
   logic        b_term, b_roll, b_lerr;
   // DUT C: NUM_DIGITS=1, SATURATE=0
   logic        c_en, c_ud, c_clr, c_ld;
   logic [3:0]  c_lv, c_cnt;
   logic        c_term, c_roll, c_lerr;

   int checks = 0;
   int errors = 0;

   bcd_updown_counter_n #(.NUM_DIGITS(3), .SATURATE(0)) dut_a (
      .clk(clk), .reset_n(reset_n), .enable(a_en), .up_dn(a_ud), .clear(a_clr),
      .load(a_ld), .load_value(a_lv), .count(a_cnt), .terminal(a_term),
      .rollover(a_roll), .load_err(a_lerr));

   bcd_updown_counter_n #(.NUM_DIGITS(3), .SATURATE(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .enable(b_en), .up_dn(b_ud), .clear(b_clr),
      .load(b_ld), .load_value(b_lv), .count(b_cnt), .terminal(b_term),
      .rollover(b_roll), .load_err(b_lerr));

   bcd_updown_counter_n #(.NUM_DIGITS(1), .SATURATE(0)) dut_c (
      .clk(clk), .reset_n(reset_n), .enable(c_en), .up_dn(c_ud), .clear(c_clr),
      .load(c_ld), .load_value(c_lv), .count(c_cnt), .terminal(c_term),
      .rollover(c_roll), .load_err(c_lerr));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic        clr;
      logic        ld;
      logic        en;
      logic        ud;
      logic [11:0] lv;
      logic [11:0] exp_cnt;
      logic        exp_term;
      logic        exp_roll;
      logic        exp_lerr;
   } vec_t;

   vec_t tv[20];

   function automatic vec_t mk(logic clr, logic ld, logic en, logic ud, logic [11:0] lv,
                               logic [11:0] ec, logic et, logic er, logic el);
      vec_t v;
      v.clr = clr; v.ld = ld; v.en = en; v.ud = ud; v.lv = lv;
      v.exp_cnt = ec; v.exp_term = et; v.exp_roll = er; v.exp_lerr = el;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic clr, input logic ld, input logic en, input logic ud,
                          input logic [11:0] lv);
      a_clr = clr; a_ld = ld; a_en = en; a_ud = ud; a_lv = lv;
   endtask

   task automatic drive_b(input logic clr, input logic ld, input logic en, input logic ud,
                          input logic [11:0] lv);
      b_clr = clr; b_ld = ld; b_en = en; b_ud = ud; b_lv = lv;
   endtask

   task automatic drive_c(input logic clr, input logic ld, input logic en, input logic ud,
                          input logic [3:0] lv);
      c_clr = clr; c_ld = ld; c_en = en; c_ud = ud; c_lv = lv;
   endtask

   initial begin
      //          clr ld en ud  load     count   term roll lerr
      tv[0]  = mk(0, 1, 0, 1, 12'h099, 12'h099, 0, 0, 0);
      tv[1]  = mk(0, 0, 1, 1, 12'h000, 12'h100, 0, 0, 0);
      tv[2]  = mk(0, 1, 0, 1, 12'h999, 12'h999, 1, 0, 0);
      tv[3]  = mk(0, 0, 1, 1, 12'h000, 12'h000, 0, 1, 0);
      tv[4]  = mk(0, 0, 0, 1, 12'h000, 12'h000, 0, 0, 0);
      tv[5]  = mk(0, 0, 1, 0, 12'h000, 12'h999, 0, 1, 0);
      tv[6]  = mk(0, 0, 0, 0, 12'h000, 12'h999, 0, 0, 0);
      tv[7]  = mk(0, 1, 0, 1, 12'hF2A, 12'h020, 0, 0, 1);
      tv[8]  = mk(0, 1, 0, 1, 12'h345, 12'h345, 0, 0, 0);
      tv[9]  = mk(0, 0, 0, 1, 12'h000, 12'h345, 0, 0, 0);
      tv[10] = mk(1, 1, 1, 1, 12'h777, 12'h000, 0, 0, 0);
      tv[11] = mk(0, 1, 1, 1, 12'h500, 12'h500, 0, 0, 0);
      tv[12] = mk(0, 0, 1, 0, 12'h000, 12'h499, 0, 0, 0);
      tv[13] = mk(0, 1, 0, 0, 12'h000, 12'h000, 1, 0, 0);
      tv[14] = mk(0, 1, 1, 1, 12'h999, 12'h999, 1, 0, 0);
      tv[15] = mk(0, 1, 1, 1, 12'h999, 12'h999, 1, 0, 0);
      tv[16] = mk(1, 0, 0, 1, 12'h000, 12'h000, 0, 0, 0);
      tv[17] = mk(0, 1, 0, 1, 12'hFFF, 12'h000, 0, 0, 1);
      tv[18] = mk(1, 1, 0, 1, 12'hFFF, 12'h000, 0, 0, 0);
      tv[19] = mk(0, 0, 1, 1, 12'h000, 12'h001, 0, 0, 0);

      reset_n = 1'b0;
      drive_a(0, 0, 0, 1, 12'h000);
      drive_b(0, 0, 0, 1, 12'h000);
      drive_c(0, 0, 0, 1, 4'h0);
      #12;
      chk("reset_count", 32'(a_cnt), 32'h000);
      chk("reset_rollover", 32'(a_roll), 0);
      chk("reset_load_err", 32'(a_lerr), 0);
      @(negedge clk);
      reset_n = 1'b1;

      // Twelve up steps from zero
      drive_a(0, 0, 1, 1, 12'h000);
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("count_up_terminal", 32'(a_term), 0);
      end
      chk("count_up_12", 32'(a_cnt), 32'h012);

      for (int i = 0; i < 20; i++) begin
         drive_a(tv[i].clr, tv[i].ld, tv[i].en, tv[i].ud, tv[i].lv);
         tick();
         chk($sformatf("vec%0d_count", i), 32'(a_cnt), 32'(tv[i].exp_cnt));
         chk($sformatf("vec%0d_terminal", i), 32'(a_term), 32'(tv[i].exp_term));
         chk($sformatf("vec%0d_rollover", i), 32'(a_roll), 32'(tv[i].exp_roll));
         chk($sformatf("vec%0d_load_err", i), 32'(a_lerr), 32'(tv[i].exp_lerr));
      end

      // Asynchronous reset mid-count at 437, then resume
      drive_a(0, 1, 0, 1, 12'h437);
      tick();
      chk("load_437", 32'(a_cnt), 32'h437);
      drive_a(0, 0, 0, 1, 12'h000);
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_count", 32'(a_cnt), 32'h000);
      reset_n = 1'b1;
      drive_a(0, 0, 1, 1, 12'h000);
      tick();
      chk("resume_after_reset", 32'(a_cnt), 32'h001);

      // Pending rollover pulse dropped by reset
      drive_a(0, 1, 0, 1, 12'h999);
      tick();
      drive_a(0, 0, 1, 1, 12'h000);
      tick();
      chk("wrap_before_reset_roll", 32'(a_roll), 1);
      drive_a(0, 0, 0, 1, 12'h000);
      #2 reset_n = 1'b0;
      #1;
      chk("reset_drops_rollover", 32'(a_roll), 0);
      reset_n = 1'b1;

      // Saturating build: hold at 999 going up and 000 going down
      drive_b(0, 1, 0, 1, 12'h999);
      tick();
      drive_b(0, 0, 1, 1, 12'h000);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("sat_up_count", 32'(b_cnt), 32'h999);
         chk("sat_up_terminal", 32'(b_term), 1);
         chk("sat_up_rollover", 32'(b_roll), 0);
      end
      drive_b(0, 1, 0, 0, 12'h000);
      tick();
      drive_b(0, 0, 1, 0, 12'h000);
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("sat_dn_count", 32'(b_cnt), 32'h000);
         chk("sat_dn_terminal", 32'(b_term), 1);
         chk("sat_dn_rollover", 32'(b_roll), 0);
      end
      drive_b(0, 0, 1, 1, 12'h000);
      tick();
      chk("sat_step_off_limit", 32'(b_cnt), 32'h001);

      // Single-digit build: 7 -> 8 -> 9 -> 0 with rollover on the wrap
      drive_c(0, 1, 0, 1, 4'h7);
      tick();
      drive_c(0, 0, 1, 1, 4'h0);
      tick();
      chk("c_up_8", 32'(c_cnt), 32'h8);
      chk("c_roll_8", 32'(c_roll), 0);
      tick();
      chk("c_up_9", 32'(c_cnt), 32'h9);
      chk("c_term_9", 32'(c_term), 1);
      tick();
      chk("c_up_0", 32'(c_cnt), 32'h0);
      chk("c_roll_0", 32'(c_roll), 1);
      drive_c(0, 0, 0, 1, 4'h0);
      tick();
      chk("c_roll_cleared", 32'(c_roll), 0);

      // Direction toggled every cycle around 5
      drive_c(0, 1, 0, 1, 4'h5);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive_c(0, 0, 1, (i % 2 == 0), 4'h0);
         tick();
         chk("c_toggle", 32'(c_cnt), (i % 2 == 0) ? 32'h6 : 32'h5);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
